// File: rtl/ysyx_25070198_mem_arbiter_if.sv
// Bundle of the IFU/LSU SimpleBus request/response pairs and the shared memory port.
// The arbiter uses the slave modport; the environment (requesters + memory) uses master.
interface ysyx_25070198_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_reqValid;
  logic              ifu_reqReady;
  logic [ADDR_W-1:0] ifu_raddr;
  logic              ifu_respValid;
  logic [DATA_W-1:0] ifu_rdata;

  logic              lsu_reqValid;
  logic              lsu_reqReady;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [3:0]        lsu_wmask;
  logic              lsu_respValid;
  logic [DATA_W-1:0] lsu_rdata;

  logic              bus_err;

  logic              mem_reqValid;
  logic              mem_reqReady;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_respValid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_reqValid, ifu_raddr,
    input  lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_reqReady, mem_respValid, mem_rdata,
    output ifu_reqReady, ifu_respValid, ifu_rdata,
    output lsu_reqReady, lsu_respValid, lsu_rdata,
    output bus_err,
    output mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_reqValid, ifu_raddr,
    output lsu_reqValid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_reqReady, mem_respValid, mem_rdata,
    input  ifu_reqReady, ifu_respValid, ifu_rdata,
    input  lsu_reqReady, lsu_respValid, lsu_rdata,
    input  bus_err,
    input  mem_reqValid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_25070198_mem_arbiter.sv
// Round-robin IFU/LSU arbiter onto a single memory port; one transaction in flight,
// error completion when the slave does not respond within TIMEOUT WAIT cycles.
module ysyx_25070198_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_25070198_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic {M_IFU, M_LSU} master_t;

  state_t            state, state_nxt;
  master_t           owner, last_grant, winner;
  logic              grant;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    grant  = bus.ifu_reqValid | bus.lsu_reqValid;
    winner = M_IFU;
    if (bus.ifu_reqValid && bus.lsu_reqValid)
      winner = (last_grant == M_LSU) ? M_IFU : M_LSU;
    else if (bus.lsu_reqValid)
      winner = M_LSU;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= M_IFU;
      last_grant <= M_LSU;
      cnt        <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= 4'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant) begin
        owner      <= winner;
        last_grant <= winner;
        if (winner == M_IFU) begin
          addr_q  <= bus.ifu_raddr;
          wen_q   <= 1'b0;
          wdata_q <= '0;
          wmask_q <= 4'h0;
        end else begin
          addr_q  <= bus.lsu_addr;
          wen_q   <= bus.lsu_wen;
          wdata_q <= bus.lsu_wdata;
          wmask_q <= bus.lsu_wmask;
        end
      end
      if (state == REQ)
        cnt <= '0;
      else if (state == WAIT && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wen   = wen_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wmask = wmask_q;

  // Everything is gated by rst so an in-flight request drops the moment reset rises.
  always_comb begin
    state_nxt         = state;
    bus.ifu_reqReady  = 1'b0;
    bus.lsu_reqReady  = 1'b0;
    bus.ifu_respValid = 1'b0;
    bus.lsu_respValid = 1'b0;
    bus.ifu_rdata     = '0;
    bus.lsu_rdata     = '0;
    bus.bus_err       = 1'b0;
    bus.mem_reqValid  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: if (grant) begin
          state_nxt = REQ;
          if (winner == M_IFU) bus.ifu_reqReady = 1'b1;
          else                 bus.lsu_reqReady = 1'b1;
        end
        REQ: begin
          bus.mem_reqValid = 1'b1;
          if (bus.mem_reqReady) state_nxt = WAIT;
        end
        WAIT: if (bus.mem_respValid || timeout_hit) begin
          state_nxt   = IDLE;
          bus.bus_err = ~bus.mem_respValid;
          if (owner == M_IFU) begin
            bus.ifu_respValid = 1'b1;
            bus.ifu_rdata     = bus.mem_respValid ? bus.mem_rdata : '0;
          end else begin
            bus.lsu_respValid = 1'b1;
            bus.lsu_rdata     = bus.mem_respValid ? bus.mem_rdata : '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter: a per-cycle vector table from reset,
// then hand sequences for slave stall, timeout and reset during WAIT.
module tb_ysyx_25070198_mem_arbiter;
  localparam logic [31:0] IA = 32'h8000_0000;
  localparam logic [31:0] LA = 32'h8000_1000;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;
  localparam int MF0 = 0, MFI = 1, MFW = 2, MFR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  ysyx_25070198_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ysyx_25070198_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv, lv, lwen, mrdy, mresp;
    logic [31:0] mrd;
    logic irdy, lrdy, mv;
    int   mf;
    logic iresp, lresp, err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic lv, input logic lwen,
                       input logic mrdy, input logic mresp, input logic [31:0] mrd);
    bus.ifu_reqValid  = iv;
    bus.lsu_reqValid  = lv;
    bus.lsu_wen       = lwen;
    bus.mem_reqReady  = mrdy;
    bus.mem_respValid = mresp;
    bus.mem_rdata     = mrd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(input string nm, input int mf);
    logic [31:0] a, d;
    logic w;
    logic [3:0] m;
    case (mf)
      MFI:     begin a = IA; w = 1'b0; d = 32'h0; m = 4'h0; end
      MFW:     begin a = LA; w = 1'b1; d = WD;    m = 4'h1; end
      MFR:     begin a = LA; w = 1'b0; d = WD;    m = 4'h1; end
      default: begin a = 32'h0; w = 1'b0; d = 32'h0; m = 4'h0; end
    endcase
    chk({nm, ".mem_addr"},  bus.mem_addr, a);
    chk({nm, ".mem_wen"},   {31'h0, bus.mem_wen}, {31'h0, w});
    chk({nm, ".mem_wdata"}, bus.mem_wdata, d);
    chk({nm, ".mem_wmask"}, {28'h0, bus.mem_wmask}, {28'h0, m});
  endtask

  task automatic chk_row(input string nm, input vec_t v);
    chk({nm, ".ifu_reqReady"},  {31'h0, bus.ifu_reqReady},  {31'h0, v.irdy});
    chk({nm, ".lsu_reqReady"},  {31'h0, bus.lsu_reqReady},  {31'h0, v.lrdy});
    chk({nm, ".mem_reqValid"},  {31'h0, bus.mem_reqValid},  {31'h0, v.mv});
    chk({nm, ".ifu_respValid"}, {31'h0, bus.ifu_respValid}, {31'h0, v.iresp});
    chk({nm, ".lsu_respValid"}, {31'h0, bus.lsu_respValid}, {31'h0, v.lresp});
    chk({nm, ".bus_err"},       {31'h0, bus.bus_err},       {31'h0, v.err});
    chk({nm, ".ifu_rdata"}, bus.ifu_rdata, v.iresp ? v.rdata : 32'h0);
    chk({nm, ".lsu_rdata"}, bus.lsu_rdata, v.lresp ? v.rdata : 32'h0);
    chk_mem(nm, v.mf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int n;
    bit seen;
    // iv lv lwen mrdy mresp mrd | irdy lrdy mv mf | iresp lresp err rdata
    tbl.push_back('{1,0,0,0,0,32'h0,        1,0,0,MF0, 0,0,0,32'h0});        // IFU accept
    tbl.push_back('{0,0,0,1,0,32'h0,        0,0,1,MFI, 0,0,0,32'h0});        // REQ handshake
    tbl.push_back('{0,0,0,0,1,32'h00100073, 0,0,0,MFI, 1,0,0,32'h00100073}); // IFU response
    tbl.push_back('{0,1,1,0,0,32'h0,        0,1,0,MFI, 0,0,0,32'h0});        // LSU write accept
    tbl.push_back('{0,0,1,1,0,32'h0,        0,0,1,MFW, 0,0,0,32'h0});
    tbl.push_back('{0,0,0,0,1,32'h0,        0,0,0,MFW, 0,1,0,32'h0});        // write ack
    tbl.push_back('{0,0,0,0,1,32'hFFFFFFFF, 0,0,0,MFW, 0,0,0,32'h0});        // stray in IDLE
    tbl.push_back('{1,1,0,0,0,32'h0,        1,0,0,MFW, 0,0,0,32'h0});        // tie -> IFU
    tbl.push_back('{1,1,0,1,0,32'h0,        0,0,1,MFI, 0,0,0,32'h0});
    tbl.push_back('{1,1,0,0,1,32'h0000000A, 0,0,0,MFI, 1,0,0,32'h0000000A});
    tbl.push_back('{1,1,0,0,0,32'h0,        0,1,0,MFI, 0,0,0,32'h0});        // tie -> LSU
    tbl.push_back('{1,1,0,1,0,32'h0,        0,0,1,MFR, 0,0,0,32'h0});
    tbl.push_back('{1,1,0,0,1,32'h0000000B, 0,0,0,MFR, 0,1,0,32'h0000000B});
    tbl.push_back('{1,1,0,0,0,32'h0,        1,0,0,MFR, 0,0,0,32'h0});        // tie -> IFU
    tbl.push_back('{1,1,0,1,0,32'h0,        0,0,1,MFI, 0,0,0,32'h0});
    tbl.push_back('{1,1,0,0,1,32'h0000000C, 0,0,0,MFI, 1,0,0,32'h0000000C});
    tbl.push_back('{1,1,0,0,0,32'h0,        0,1,0,MFI, 0,0,0,32'h0});        // tie -> LSU
    tbl.push_back('{0,0,0,0,1,32'h0000000D, 0,0,1,MFR, 0,0,0,32'h0});        // stray in REQ
    tbl.push_back('{0,0,0,1,0,32'h0,        0,0,1,MFR, 0,0,0,32'h0});
    tbl.push_back('{0,0,0,0,1,32'h0000000E, 0,0,0,MFR, 0,1,0,32'h0000000E});

    bus.ifu_raddr = IA;
    bus.lsu_addr  = LA;
    bus.lsu_wdata = WD;
    bus.lsu_wmask = 4'h1;
    drive(1, 1, 0, 0, 0, 32'h0);

    // Reset: readies must stay low even with both requesters valid.
    #2;
    v = '{1,1,0,0,0,32'h0, 0,0,0,MF0, 0,0,0,32'h0};
    chk_row("reset", v);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].lv, tbl[i].lwen, tbl[i].mrdy, tbl[i].mresp, tbl[i].mrd);
      @(negedge clk);
      chk_row($sformatf("row%0d", i), tbl[i]);
      next_cycle();
    end

    // Slave stall: request held 5 cycles, LSU waits without a grant.
    drive(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk); chk("stall.ifu_reqReady", {31'h0, bus.ifu_reqReady}, 32'h1);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 0, 32'h0);
      @(negedge clk);
      chk($sformatf("stall%0d.mem_reqValid", i), {31'h0, bus.mem_reqValid}, 32'h1);
      chk($sformatf("stall%0d.lsu_reqReady", i), {31'h0, bus.lsu_reqReady}, 32'h0);
      chk_mem($sformatf("stall%0d", i), MFI);
      next_cycle();
    end
    drive(0, 1, 0, 1, 0, 32'h0);
    @(negedge clk); chk("stall.release", {31'h0, bus.mem_reqValid}, 32'h1);
    next_cycle();
    drive(0, 1, 0, 0, 1, 32'h55);
    @(negedge clk);
    chk("stall.ifu_respValid", {31'h0, bus.ifu_respValid}, 32'h1);
    chk("stall.ifu_rdata", bus.ifu_rdata, 32'h55);
    chk("stall.lsu_reqReady_busy", {31'h0, bus.lsu_reqReady}, 32'h0);
    next_cycle();
    drive(0, 1, 0, 0, 0, 32'h0);
    @(negedge clk); chk("stall.lsu_grant", {31'h0, bus.lsu_reqReady}, 32'h1);
    next_cycle();
    drive(0, 0, 0, 1, 0, 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 1, 32'h66);
    @(negedge clk); chk("stall.lsu_respValid", {31'h0, bus.lsu_respValid}, 32'h1);
    next_cycle();

    // Timeout: slave never answers, completion after exactly 8 WAIT cycles.
    drive(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk); chk("to.ifu_reqReady", {31'h0, bus.ifu_reqReady}, 32'h1);
    next_cycle();
    drive(0, 0, 0, 1, 0, 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'hFFFFFFFF);
    n = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus.ifu_respValid) begin
        seen = 1;
        chk("to.ifu_rdata", bus.ifu_rdata, 32'h0);
        chk("to.bus_err", {31'h0, bus.bus_err}, 32'h1);
        chk("to.lsu_respValid", {31'h0, bus.lsu_respValid}, 32'h0);
      end else begin
        chk($sformatf("to.wait%0d.bus_err", n), {31'h0, bus.bus_err}, 32'h0);
      end
      next_cycle();
    end
    chk("to.seen", {31'h0, seen}, 32'h1);
    chk("to.wait_cycles", n, 32'd8);
    drive(1, 0, 0, 0, 0, 32'h0);
    @(negedge clk);
    chk("to.rearb", {31'h0, bus.ifu_reqReady}, 32'h1);
    chk("to.err_cleared", {31'h0, bus.bus_err}, 32'h0);
    next_cycle();

    // Reset while in WAIT; late response must be dropped, tie goes to IFU again.
    drive(0, 0, 0, 1, 0, 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    #1;
    v = '{0,0,0,0,0,32'h0, 0,0,0,MF0, 0,0,0,32'h0};
    chk_row("rstwait", v);
    drive(1, 1, 0, 0, 1, 32'h77);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    v = '{1,1,0,0,1,32'h77, 1,0,0,MF0, 0,0,0,32'h0};
    chk_row("post_rst", v);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
